// File: rtl/trunc_sched_pkg.sv
// Shared types and defaults for the truncating round-robin scheduler.
// cfg_t describes the cfg_data layout {ch, nbits} for the default channel count.
package trunc_sched_pkg;

   localparam int NBW_DEF = 5;
   localparam int NCH_DEF = 4;
   localparam int CHW_DEF = $clog2(NCH_DEF);

   typedef enum logic {
      StIdle,
      StLock
   } state_e;

   typedef struct packed {
      logic [CHW_DEF-1:0] ch;
      logic [NBW_DEF-1:0] nbits;
   } cfg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: the first requester strictly after ptr (wrapping) wins.
// Output is a one-hot grant, all zeros when nothing requests.
module rr_arbiter
   import trunc_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt
);

   localparam int CW = $clog2(N);

   logic [CW-1:0] idx;
   logic          found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= N; i++) begin
         idx = CW'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/trunc_sched.sv
// Multi-channel burst scheduler: round-robin grant, burst lock until eot,
// per-channel LSB truncation and a single output register stage.
module trunc_sched
   import trunc_sched_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int DIN       = 16,
   parameter int NBW       = NBW_DEF,
   parameter int NBITS_RST = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NCH-1:0]              din_valid,
   output logic [NCH-1:0]              din_ready,
   input  logic [NCH*DIN-1:0]          din_data,
   input  logic [NCH-1:0]              din_eot,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [$clog2(NCH)+NBW-1:0]  cfg_data,
   input  logic                        dout_ready,
   output logic                        dout_valid,
   output logic [DIN-1:0]              dout_data,
   output logic [$clog2(NCH)-1:0]      dout_ch,
   output logic                        dout_eot
);

   localparam int CW = $clog2(NCH);

   state_e          state_q, state_d;
   logic [CW-1:0]   ptr_q, ptr_d;
   logic [NBW-1:0]  nbits_q [NCH];

   logic [NCH-1:0]  arb_gnt, gnt;
   logic [CW-1:0]   sel;
   logic [DIN-1:0]  data_sel, mask, trunc;
   logic [NBW-1:0]  nb_sel;
   logic            eot_sel;
   logic            can_take;
   logic            accept;
   logic [CW-1:0]   cfg_ch;
   logic [NBW-1:0]  cfg_nb;

   assign cfg_ready = 1'b1;
   assign cfg_ch    = cfg_data[CW+NBW-1:NBW];
   assign cfg_nb    = cfg_data[NBW-1:0];

   rr_arbiter #(
      .N(NCH)
   ) u_arb (
      .req(din_valid),
      .ptr(ptr_q),
      .gnt(arb_gnt)
   );

   // In LOCK the pointer holds the burst owner, so the grant is pinned to it.
   assign gnt       = (state_q == StLock) ? (NCH'(1) << ptr_q) : arb_gnt;
   assign can_take  = !dout_valid || dout_ready;
   assign din_ready = gnt & {NCH{can_take && !rst}};
   assign accept    = |(din_valid & din_ready);

   always_comb begin
      sel = '0;
      for (int k = 0; k < NCH; k++) begin
         if (gnt[k]) sel = CW'(k);
      end
   end

   always_comb begin
      data_sel = '0;
      nb_sel   = '0;
      eot_sel  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (sel == CW'(k)) begin
            data_sel = din_data[k*DIN +: DIN];
            nb_sel   = nbits_q[k];
            eot_sel  = din_eot[k];
         end
      end
   end

   // Shifting by DIN or more leaves an all-zero mask.
   assign mask  = {DIN{1'b1}} << nb_sel;
   assign trunc = data_sel & mask;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (accept) begin
         ptr_d = sel;
         unique case (state_q)
            StIdle:  if (!eot_sel) state_d = StLock;
            StLock:  if (eot_sel) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= CW'(NCH - 1);
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) nbits_q[k] <= NBW'(NBITS_RST);
      end else if (cfg_valid) begin
         for (int k = 0; k < NCH; k++) begin
            if (cfg_ch == CW'(k)) nbits_q[k] <= cfg_nb;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_valid <= 1'b0;
         dout_data  <= '0;
         dout_ch    <= '0;
         dout_eot   <= 1'b0;
      end else if (accept) begin
         dout_valid <= 1'b1;
         dout_data  <= trunc;
         dout_ch    <= sel;
         dout_eot   <= eot_sel;
      end else if (dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_trunc_sched.sv
// Self-checking bench for trunc_sched: per-channel beat producers feed a
// scoreboard; hand sequences cover fairness, burst lock, stalls, reset and cfg race.
module tb_trunc_sched;
   import trunc_sched_pkg::*;

   localparam int NCH = 4;
   localparam int DIN = 16;
   localparam int NBW = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH-1:0]   din_valid;
   logic [NCH-1:0]   din_ready;
   logic [NCH*DIN-1:0] din_data;
   logic [NCH-1:0]   din_eot;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [6:0]       cfg_data;
   logic             dout_ready;
   logic             dout_valid;
   logic [DIN-1:0]   dout_data;
   logic [1:0]       dout_ch;
   logic             dout_eot;

   always #5 clk = ~clk;

   trunc_sched #(
      .NCH(NCH),
      .DIN(DIN),
      .NBW(NBW),
      .NBITS_RST(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .din_valid(din_valid),
      .din_ready(din_ready),
      .din_data(din_data),
      .din_eot(din_eot),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_data(cfg_data),
      .dout_ready(dout_ready),
      .dout_valid(dout_valid),
      .dout_data(dout_data),
      .dout_ch(dout_ch),
      .dout_eot(dout_eot)
   );

   typedef struct {
      logic [15:0] d;
      logic [1:0]  ch;
      logic        eot;
   } exp_t;

   typedef struct {
      logic [4:0]  nb;
      logic [15:0] d;
      logic [15:0] e;
   } tvec_t;

   exp_t        sbq[$];
   int          obs_ch[$];
   logic [15:0] obs_d[$];
   int          exp_seq[$];
   int          ncmp = 0;
   int          nerr = 0;
   int          cyc = 0;
   int          first_cyc = 0;
   int          last_cyc = 0;
   int          rem[4];
   int          blen[4];
   int          bidx[4];
   int          seqn[4];
   logic [15:0] base[4];
   logic [4:0]  model_nb[4];
   logic        stalled_prev = 1'b0;
   logic [15:0] pd;
   logic [1:0]  pch;
   logic        peot;
   tvec_t       tv[8];

   function automatic logic [15:0] model_trunc(input logic [15:0] d, input logic [4:0] nb);
      logic [15:0] r;
      r = d;
      for (int i = 0; i < 16; i++) if (i < int'(nb)) r[i] = 1'b0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply();
      for (int k = 0; k < NCH; k++) begin
         din_valid[k]           = rem[k] > 0;
         din_data[k*DIN +: DIN] = base[k] + 16'(seqn[k]);
         din_eot[k]             = (bidx[k] == blen[k] - 1);
      end
   endtask

   task automatic start_prod(input int ch, input int n, input int bl, input logic [15:0] b);
      rem[ch]  = n;
      blen[ch] = bl;
      bidx[ch] = 0;
      seqn[ch] = 0;
      base[ch] = b;
      apply();
   endtask

   task automatic monitor();
      exp_t e;
      cfg_t c;
      if (dout_valid && dout_ready) begin
         if (sbq.size() == 0) begin
            ncmp++;
            nerr++;
            $display("FAIL unexpected_out: got ch %0d data 0x%0h, expected no output",
                     dout_ch, dout_data);
         end else begin
            e = sbq.pop_front();
            chk("out_data", 32'(dout_data), 32'(e.d));
            chk("out_ch", 32'(dout_ch), 32'(e.ch));
            chk("out_eot", 32'(dout_eot), 32'(e.eot));
         end
         if (obs_ch.size() == 0) first_cyc = cyc;
         last_cyc = cyc;
         obs_ch.push_back(int'(dout_ch));
         obs_d.push_back(dout_data);
      end
      if (dout_valid && !dout_ready) begin
         chk("stall_din_ready", 32'(din_ready), 32'd0);
         if (stalled_prev) begin
            chk("stall_hold_data", 32'(dout_data), 32'(pd));
            chk("stall_hold_ch", 32'(dout_ch), 32'(pch));
            chk("stall_hold_eot", 32'(dout_eot), 32'(peot));
         end
      end
      stalled_prev = dout_valid && !dout_ready;
      pd   = dout_data;
      pch  = dout_ch;
      peot = dout_eot;
      for (int k = 0; k < NCH; k++) begin
         if (din_valid[k] && din_ready[k]) begin
            e.d   = model_trunc(din_data[k*DIN +: DIN], model_nb[k]);
            e.ch  = 2'(k);
            e.eot = din_eot[k];
            sbq.push_back(e);
            rem[k]--;
            seqn[k]++;
            bidx[k] = (bidx[k] == blen[k] - 1) ? 0 : bidx[k] + 1;
         end
      end
      // A beat accepted alongside a cfg write still used the old amount above.
      if (cfg_valid) begin
         c = cfg_t'(cfg_data);
         model_nb[c.ch] = c.nbits;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      apply();
      cyc++;
   endtask

   task automatic set_cfg(input int ch, input int nb);
      cfg_t c;
      c.ch      = 2'(ch);
      c.nbits   = 5'(nb);
      cfg_valid = 1'b1;
      cfg_data  = c;
   endtask

   function automatic bit busy();
      for (int k = 0; k < NCH; k++) if (rem[k] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((sbq.size() != 0 || busy() || dout_valid) && t < 300) begin
         tick();
         t++;
      end
      if (t >= 300) begin
         ncmp++;
         nerr++;
         $display("FAIL %s_timeout: got %0d pending beats after 300 cycles, expected 0", name,
                  sbq.size());
      end
   endtask

   task automatic chk_seq(input string name);
      chk({name, "_len"}, 32'(obs_ch.size()), 32'(exp_seq.size()));
      for (int i = 0; i < exp_seq.size() && i < obs_ch.size(); i++) begin
         chk($sformatf("%s_ch[%0d]", name, i), 32'(obs_ch[i]), 32'(exp_seq[i]));
      end
   endtask

   task automatic clear_obs();
      obs_ch.delete();
      obs_d.delete();
   endtask

   task automatic single(input int ch);
      start_prod(ch, 1, 1, 16'h0100 * 16'(ch));
      drain("single");
   endtask

   initial begin
      tv[0] = '{nb: 5'd4,  d: 16'hFFFF, e: 16'hFFF0};
      tv[1] = '{nb: 5'd20, d: 16'hFFFF, e: 16'h0000};
      tv[2] = '{nb: 5'd0,  d: 16'hFFFF, e: 16'hFFFF};
      tv[3] = '{nb: 5'd8,  d: 16'hABCD, e: 16'hAB00};
      tv[4] = '{nb: 5'd15, d: 16'hFFFF, e: 16'h8000};
      tv[5] = '{nb: 5'd16, d: 16'h1234, e: 16'h0000};
      tv[6] = '{nb: 5'd1,  d: 16'h0003, e: 16'h0002};
      tv[7] = '{nb: 5'd31, d: 16'hFFFF, e: 16'h0000};

      for (int k = 0; k < NCH; k++) begin
         rem[k] = 0; blen[k] = 1; bidx[k] = 0; seqn[k] = 0; base[k] = '0; model_nb[k] = '0;
      end
      rst        = 1'b1;
      cfg_valid  = 1'b0;
      cfg_data   = '0;
      dout_ready = 1'b1;
      din_data   = '0;
      din_eot    = '0;
      din_valid  = 4'hF;
      #3;
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_dout_data", 32'(dout_data), 32'd0);
      chk("rst_dout_ch", 32'(dout_ch), 32'd0);
      chk("rst_dout_eot", 32'(dout_eot), 32'd0);
      chk("rst_din_ready", 32'(din_ready), 32'd0);
      chk("cfg_ready", 32'(cfg_ready), 32'd1);
      apply();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      // First grant after reset goes to ch0 with one cycle of latency.
      start_prod(0, 1, 1, 16'hABCD);
      tick();
      chk("first_valid", 32'(dout_valid), 32'd1);
      chk("first_data", 32'(dout_data), 32'hABCD);
      chk("first_ch", 32'(dout_ch), 32'd0);
      drain("first");

      for (int i = 0; i < 8; i++) begin
         set_cfg(1, int'(tv[i].nb));
         tick();
         start_prod(1, 1, 1, tv[i].d);
         tick();
         chk($sformatf("trunc[%0d]", i), 32'(dout_data), 32'(tv[i].e));
         drain("trunc");
      end
      set_cfg(1, 0);
      tick();

      single(3);
      clear_obs();
      for (int k = 0; k < NCH; k++) start_prod(k, 3, 1, 16'h1000 * 16'(k));
      drain("fair");
      exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
      chk_seq("fair");
      chk("fair_tput", 32'(last_cyc - first_cyc + 1), 32'd12);

      single(1);
      clear_obs();
      start_prod(2, 3, 3, 16'h2200);
      start_prod(0, 1, 1, 16'h0A00);
      start_prod(3, 1, 1, 16'h3300);
      drain("burst");
      exp_seq = '{2, 2, 2, 3, 0};
      chk_seq("burst");

      clear_obs();
      for (int k = 0; k < NCH; k++) start_prod(k, 4, 1, 16'h4000 + 16'h0100 * 16'(k));
      repeat (3) tick();
      dout_ready = 1'b0;
      repeat (5) tick();
      dout_ready = 1'b1;
      drain("bp");
      exp_seq = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
      chk_seq("bp");

      // Reset in the middle of a locked ch1 burst, with ch0 waiting.
      start_prod(1, 4, 4, 16'h1100);
      repeat (2) tick();
      start_prod(0, 2, 1, 16'h0A00);
      rst = 1'b1;
      #1;
      chk("rstlock_dout_valid", 32'(dout_valid), 32'd0);
      chk("rstlock_din_ready", 32'(din_ready), 32'd0);
      sbq.delete();
      for (int k = 0; k < NCH; k++) model_nb[k] = '0;
      start_prod(1, 4, 4, 16'h1100);
      start_prod(0, 1, 1, 16'h0A00);
      repeat (2) tick();
      clear_obs();
      rst = 1'b0;
      drain("rstlock");
      exp_seq = '{0, 1, 1, 1, 1};
      chk_seq("rstlock");

      clear_obs();
      set_cfg(2, 8);
      start_prod(2, 2, 1, 16'h7777);
      drain("race");
      chk("race_len", 32'(obs_d.size()), 32'd2);
      if (obs_d.size() == 2) begin
         chk("race_old_nbits", 32'(obs_d[0]), 32'h7777);
         chk("race_new_nbits", 32'(obs_d[1]), 32'h7700);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
